// File: rtl/alu_exec_if.sv
// Request/response bundle for alu_exec_unit: operand handshake in, result handshake out.
interface alu_exec_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            busy;

   modport master (
      output in_valid, alu_ctrl, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, zero, busy
   );

   modport slave (
      input  in_valid, alu_ctrl, op_a, op_b, out_ready,
      output in_ready, out_valid, result, zero, busy
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute unit: single-cycle logic/arith ops, shifts done one bit per cycle
// (no barrel shifter), valid/ready on both sides, synchronous flush.
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   alu_exec_if.slave bus
);
   localparam logic [3:0] C_SUB  = 4'b0001;
   localparam logic [3:0] C_AND  = 4'b0010;
   localparam logic [3:0] C_OR   = 4'b0011;
   localparam logic [3:0] C_XOR  = 4'b0100;
   localparam logic [3:0] C_SLT  = 4'b0101;
   localparam logic [3:0] C_SLTU = 4'b0110;
   localparam logic [3:0] C_SLL  = 4'b0111;
   localparam logic [3:0] C_SRL  = 4'b1000;
   localparam logic [3:0] C_SRA  = 4'b1001;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state;
   logic [3:0]      op;
   logic [XLEN-1:0] sreg;
   logic [4:0]      cnt;
   logic [XLEN-1:0] result_q;
   logic            zero_q;
   logic            out_valid_q;

   logic [4:0]      shamt;
   logic            is_shift;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] sh_next;

   assign shamt    = bus.op_b[4:0];
   assign is_shift = (bus.alu_ctrl == C_SLL) || (bus.alu_ctrl == C_SRL) ||
                     (bus.alu_ctrl == C_SRA);

   // Shift ops fall through to op_a here: that is the shamt==0 result.
   always_comb begin
      alu_res = bus.op_a + bus.op_b;
      case (bus.alu_ctrl)
         C_SUB:                alu_res = bus.op_a - bus.op_b;
         C_AND:                alu_res = bus.op_a & bus.op_b;
         C_OR:                 alu_res = bus.op_a | bus.op_b;
         C_XOR:                alu_res = bus.op_a ^ bus.op_b;
         C_SLT:                alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
         C_SLTU:               alu_res = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
         C_SLL, C_SRL, C_SRA:  alu_res = bus.op_a;
         default:              alu_res = bus.op_a + bus.op_b;
      endcase
   end

   always_comb begin
      sh_next = {sreg[XLEN-1], sreg[XLEN-1:1]};
      case (op)
         C_SLL:   sh_next = {sreg[XLEN-2:0], 1'b0};
         C_SRL:   sh_next = {1'b0, sreg[XLEN-1:1]};
         default: sh_next = {sreg[XLEN-1], sreg[XLEN-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op          <= '0;
         sreg        <= '0;
         cnt         <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               op <= bus.alu_ctrl;
               if (is_shift && shamt != 5'd0) begin
                  sreg  <= bus.op_a;
                  cnt   <= shamt;
                  state <= SHIFT;
               end else begin
                  result_q    <= alu_res;
                  zero_q      <= (alu_res == '0);
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            SHIFT: begin
               sreg <= sh_next;
               cnt  <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  result_q    <= sh_next;
                  zero_q      <= (sh_next == '0);
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: if (bus.out_ready) begin
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, corner sequences, random ops vs model.
module tb_alu_exec_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   int   total = 0;
   int   bad = 0;

   alu_exec_if #(.XLEN(32)) bus ();
   alu_exec_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // Reference: plain operator semantics, shifts as one-shot shifts.
   function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh = b % 32;
      case (c)
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd6: return (a < b) ? 32'd1 : 32'd0;
         4'd7: return a << sh;
         4'd8: return a >> sh;
         4'd9: return 32'($signed(a) >>> sh);
         default: return a + b;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] c, input logic [31:0] b);
      if (c >= 4'd7 && c <= 4'd9 && (b % 32) != 0) return int'(b % 32) + 1;
      return 1;
   endfunction

   // Drive a request for one edge, then scramble the operand pins.
   task automatic start(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = c;
      bus.op_a     = a;
      bus.op_b     = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.alu_ctrl = 4'($urandom);
      bus.op_a     = $urandom;
      bus.op_b     = $urandom;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      bus.out_ready = 1'b1;
      start(c, a, b);
      wait_valid(lat);
      check({name, " result"}, bus.result, exp);
      check({name, " zero"}, 32'(bus.zero), 32'(exp == 32'd0));
      check({name, " latency"}, lat, exp_lat);
      @(posedge clk); #1;
      check({name, " in_ready after"}, 32'(bus.in_ready), 32'd1);
   endtask

   vec_t vecs[$];

   initial begin
      int lat;
      logic [31:0] held;
      bus.in_valid  = 1'b0;
      bus.alu_ctrl  = 4'd0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.out_ready = 1'b1;

      vecs.push_back('{4'd0, 32'd7, 32'd5, 32'd12, 1});
      vecs.push_back('{4'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 1});
      vecs.push_back('{4'd1, 32'd9, 32'd9, 32'd0, 1});
      vecs.push_back('{4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 1});
      vecs.push_back('{4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1});
      vecs.push_back('{4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1});
      vecs.push_back('{4'd3, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1});
      vecs.push_back('{4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1});
      vecs.push_back('{4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 5});
      vecs.push_back('{4'd7, 32'd1, 32'd31, 32'h8000_0000, 32});
      vecs.push_back('{4'd8, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF, 1});
      vecs.push_back('{4'd7, 32'h0000_0013, 32'hFFFF_FFE3, 32'h0000_0098, 4});
      vecs.push_back('{4'd8, 32'h8000_0000, 32'd31, 32'h0000_0001, 32});
      vecs.push_back('{4'd15, 32'd3, 32'd4, 32'd7, 1});
      vecs.push_back('{4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0, 1});

      #12;
      check("reset in_ready", 32'(bus.in_ready), 32'd1);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset zero", 32'(bus.zero), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

      // Backpressure: result frozen, extra requests ignored.
      bus.out_ready = 1'b0;
      start(4'd0, 32'd7, 32'd5);
      wait_valid(lat);
      check("bp latency", lat, 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.alu_ctrl = 4'd1;
         bus.op_a     = 32'd100;
         bus.op_b     = 32'd1;
         @(posedge clk); #1;
         check("bp out_valid", 32'(bus.out_valid), 32'd1);
         check("bp result", bus.result, 32'd12);
         check("bp zero", 32'(bus.zero), 32'd0);
         check("bp in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", 32'(bus.out_valid), 32'd0);
      check("bp release in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      check("bp pulse not accepted", 32'(bus.busy), 32'd0);

      // Async reset in the middle of a long shift.
      start(4'd7, 32'd1, 32'd20);
      repeat (8) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst out_valid", 32'(bus.out_valid), 32'd0);
      check("rst result", bus.result, 32'd0);
      check("rst in_ready", 32'(bus.in_ready), 32'd1);
      check("rst busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post-rst add", 4'd0, 32'd1, 32'd1, 32'd2, 1);

      // Flush during a shift.
      held = bus.result;
      start(4'd8, 32'hFFFF_0000, 32'd10);
      repeat (3) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy", 32'(bus.busy), 32'd0);
      check("flush in_ready", 32'(bus.in_ready), 32'd1);
      check("flush out_valid", 32'(bus.out_valid), 32'd0);
      check("flush result held", bus.result, held);
      lat = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.out_valid) lat++;
      end
      check("flush no late valid", lat, 0);

      // Flush on the accept edge drops the request.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.alu_ctrl = 4'd0;
      bus.op_a     = 32'd50;
      bus.op_b     = 32'd60;
      flush        = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      flush        = 1'b0;
      check("flush-accept busy", 32'(bus.busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("flush-accept out_valid", 32'(bus.out_valid), 32'd0);
      check("flush-accept result", bus.result, held);

      // Random operations against the reference model.
      for (int n = 0; n < 150; n++) begin
         logic [3:0]  c;
         logic [31:0] a;
         logic [31:0] b;
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         if (n % 4 == 0) b = b & 32'hFFFF_FFE7;
         if (n % 7 == 0) a = b;
         run_op($sformatf("rnd%0d op%0d", n, c), c, a, b, model(c, a, b), model_lat(c, b));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end
endmodule
